rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single-port synchronous instruction ROM between the core's fetch port (if_*) and
//  data-load port (d_*), e.g. for constant tables in ROM. Drives the ROM address, tracks the
//  owner of the 1-cycle-latency read, and routes rom_rdata back with a per-port rvalid.
//  Sits between the core and the ROM instance; throughput is one access per cycle.
// PARAMETERS
//  DATA_WIDTH  32  ROM word width; must match the ROM.
//  ADDR_WIDTH  10  ROM word-address width; ports take byte addresses of ADDR_WIDTH+2 bits.
//  MAX_WAIT    4   consecutive fetch denials before fetch is forced to win (priority mode only).
// PORTS
//  clk            in   1             rising-edge clock
//  rst_n          in   1             asynchronous active-low reset
//  if_req         in   1             fetch request; held with if_addr stable until if_gnt
//  if_addr        in   ADDR_WIDTH+2  fetch byte address
//  if_gnt         out  1             fetch accepted this cycle (combinational)
//  if_rvalid      out  1             fetch data/err valid (one cycle per grant)
//  if_rdata       out  DATA_WIDTH    fetch data; 0 when if_rvalid=0 or if_err=1
//  if_err         out  1             misaligned fetch; qualified by if_rvalid
//  d_req/d_addr/d_gnt/d_rvalid/d_rdata/d_err   same as if_* for the data port
//  rom_addr       out  ADDR_WIDTH    word address to ROM (= winner addr[ADDR_WIDTH+1:2])
//  rom_rdata      in   DATA_WIDTH    ROM registered read data
//  rom_rdata_valid in  1             ROM data valid for the outstanding read
// BEHAVIOUR
//  - Reset: all gnt/rvalid/err 0, rdata 0, rom_addr 0, FSM IDLE, wait_cnt 0, no owner. Reset
//    mid-access drops the outstanding read; no rvalid is produced after rst_n deasserts.
//  - FSM: IDLE (nothing outstanding), RESP (read outstanding), HOLD (rom_rdata_valid was low).
//    IDLE: grant -> RESP. RESP: rom_rdata_valid=1 -> respond; new grant same cycle -> RESP,
//    else IDLE. RESP with rom_rdata_valid=0 -> HOLD. HOLD: no grants; stays until
//    rom_rdata_valid=1, then responds -> IDLE.
//  - Grants allowed only in IDLE, or in RESP with rom_rdata_valid=1; at most one gnt per cycle.
//  - Latency: grant in cycle N -> <port>_rvalid in cycle N+1 (longer only via HOLD).
//  - Arbitration (default): d wins over if; wait_cnt counts cycles with if_req=1 and no if_gnt
//    (saturates at MAX_WAIT); when wait_cnt==MAX_WAIT and both request, if wins. wait_cnt
//    clears on if_gnt or if_req=0.
//  - Misaligned addr (addr[1:0]!=0): granted normally, ROM read still issued, response returns
//    err=1 and rdata=0. rom_addr holds its last value when no grant is issued.
//  - Owner flag (1 bit) plus err flag registered at grant; rdata muxed from rom_rdata by owner.
//  - Requester rule: req may drop only after gnt; dropping without gnt is a protocol error
//    (assertion in sim), and the arbiter simply re-arbitrates.
// CONFIGURATION
//  ROM_ARB_RR_EN defined: strict round-robin; a 1-bit last-winner register gives the other port
//    priority on contention; wait_cnt and MAX_WAIT are unused.
//  ROM_ARB_RR_EN undefined: fixed d-over-if priority with MAX_WAIT starvation guard (above).
// TESTING
//  1 if_req only, addr 0x0,0x4,0x8 back-to-back -> if_gnt each cycle, rom_addr 0,1,2, if_rvalid
//    cycles 1..3 with ROM words 0..2.
//  2 if_req and d_req held, MAX_WAIT=4 -> d granted 4 cycles, then if granted in cycle 5,
//    wait_cnt back to 0.
//  3 d_addr=0x6 -> d_gnt, next cycle d_rvalid=1, d_err=1, d_rdata=0; if_rvalid stays 0.
//  4 rom_rdata_valid low 2 cycles after grant -> HOLD, no grants, rvalid late by 2 cycles.
//  5 rst_n low the cycle after grant -> no rvalid after release, outputs at reset values.
//  6 ROM_ARB_RR_EN, both req held 6 cycles -> grants alternate d,if,d,if,d,if.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Shares one single-port synchronous ROM between a fetch port (if_*) and a data port (d_*).
// Build option ROM_ARB_RR_EN selects round-robin arbitration instead of d-priority with a starvation guard.
module rom_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WAIT   = 4,
  localparam int WAIT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH+1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH+1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  input  logic                  rom_rdata_valid,
  output logic [1:0]            dbg_state,
  output logic [WAIT_W-1:0]     dbg_wait_cnt
);

  // Handshake: a port's req is held with a stable addr until the cycle its gnt is high;
  // that cycle transfers the request. Each gnt yields exactly one rvalid cycle on that port.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  owner_d_q, owner_d_d;  // 1: outstanding read belongs to d port
  logic                  err_q, err_d;
  logic                  can_grant, pick_d, any_gnt, resp_fire;
  logic [ADDR_WIDTH+1:0] win_addr;

`ifdef ROM_ARB_RR_EN
  logic last_d_q, last_d_d;
`else
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    // rst_n gates grants so nothing is accepted while reset is asserted
    can_grant = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rom_rdata_valid));
    resp_fire = (state_q != ST_IDLE) && rom_rdata_valid;
`ifdef ROM_ARB_RR_EN
    pick_d = d_req && (!if_req || !last_d_q);
`else
    pick_d = d_req && !(if_req && (wait_cnt_q == WAIT_W'(MAX_WAIT)));
`endif
    d_gnt    = can_grant && pick_d;
    if_gnt   = can_grant && if_req && !pick_d;
    any_gnt  = d_gnt || if_gnt;
    win_addr = pick_d ? d_addr : if_addr;
    rom_addr = any_gnt ? win_addr[ADDR_WIDTH+1:2] : rom_addr_q;

    rom_addr_d = rom_addr;
    owner_d_d  = owner_d_q;
    err_d      = err_q;
    if (any_gnt) begin
      owner_d_d = pick_d;
      err_d     = |win_addr[1:0];
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_gnt) state_d = ST_RESP;
      ST_RESP: begin
        if (rom_rdata_valid) state_d = any_gnt ? ST_RESP : ST_IDLE;
        else                 state_d = ST_HOLD;
      end
      ST_HOLD: if (rom_rdata_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef ROM_ARB_RR_EN
    last_d_d     = any_gnt ? pick_d : last_d_q;
    dbg_wait_cnt = '0;
`else
    // Counts cycles fetch was left waiting; saturates so it forces exactly one fetch win.
    if (if_req && !if_gnt)
      wait_cnt_d = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    else
      wait_cnt_d = '0;
    dbg_wait_cnt = wait_cnt_q;
`endif

    if_rvalid = resp_fire && !owner_d_q;
    d_rvalid  = resp_fire && owner_d_q;
    if_err    = if_rvalid && err_q;
    d_err     = d_rvalid && err_q;
    if_rdata  = (if_rvalid && !err_q) ? rom_rdata : '0;
    d_rdata   = (d_rvalid && !err_q) ? rom_rdata : '0;
    dbg_state = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      owner_d_q  <= 1'b0;
      err_q      <= 1'b0;
`ifdef ROM_ARB_RR_EN
      last_d_q   <= 1'b0;
`else
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      owner_d_q  <= owner_d_d;
      err_q      <= err_d;
`ifdef ROM_ARB_RR_EN
      last_d_q   <= last_d_d;
`else
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

`ifndef SYNTHESIS
  a_if_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (if_req && !if_gnt) |=> if_req);
  a_d_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (d_req && !d_gnt) |=> d_req);
  a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(if_gnt && d_gnt));
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter; the ROM is modelled as a registered read of a fixed pattern.
module tb_rom_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int WW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_req;
  logic [AW+1:0] if_addr, d_addr;
  logic          if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
  logic [DW-1:0] if_rdata, d_rdata, rom_rdata;
  logic [AW-1:0] rom_addr;
  logic          rom_rdata_valid;
  logic [1:0]    dbg_state;
  logic [WW-1:0] dbg_wait_cnt;
  int checks = 0;
  int failures = 0;

  rom_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata), .rom_rdata_valid(rom_rdata_valid),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  always #5 clk = ~clk;

  // ROM word at address a is 0x5A000000 | a, one-cycle registered read
  always @(posedge clk) rom_rdata <= 32'h5A00_0000 | {22'd0, rom_addr};

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; if_addr = '0; d_addr = '0;
    rom_rdata_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; if_addr = 12'h10; d_addr = 12'h20;
    rom_rdata_valid = 1'b1;
    #1;
    checks++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin failures++;
      $display("FAIL reset_gnt: if_gnt=%b d_gnt=%b expected 0 0", if_gnt, d_gnt); end
    checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_err !== 1'b0 || d_err !== 1'b0) begin
      failures++; $display("FAIL reset_rvalid: if_rv=%b d_rv=%b if_err=%b d_err=%b expected 0",
                           if_rvalid, d_rvalid, if_err, d_err); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0 || rom_addr !== 10'd0) begin failures++;
      $display("FAIL reset_data: if_rdata=%h d_rdata=%h rom_addr=%0d expected 0", if_rdata, d_rdata, rom_addr); end
    checks++; if (dbg_state !== 2'd0 || dbg_wait_cnt !== 3'd0) begin failures++;
      $display("FAIL reset_state: state=%0d wait=%0d expected 0 0", dbg_state, dbg_wait_cnt); end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_back_to_back();
    logic [DW-1:0] exp_data [3];
    exp_data[0] = 32'h5A00_0000; exp_data[1] = 32'h5A00_0001; exp_data[2] = 32'h5A00_0002;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if_req  = (c < 3);
      if_addr = 12'(c * 4);
      #1;
      checks++; if (if_gnt !== (c < 3)) begin failures++;
        $display("FAIL b2b_gnt c%0d: if_gnt=%b expected %b", c, if_gnt, (c < 3)); end
      checks++; if (rom_addr !== 10'((c < 3) ? c : 2)) begin failures++;
        $display("FAIL b2b_rom_addr c%0d: rom_addr=%0d expected %0d", c, rom_addr, (c < 3) ? c : 2); end
      checks++; if (if_rvalid !== (c >= 1 && c <= 3) || d_rvalid !== 1'b0) begin failures++;
        $display("FAIL b2b_rvalid c%0d: if_rvalid=%b d_rvalid=%b expected %b 0", c, if_rvalid, d_rvalid,
                 (c >= 1 && c <= 3)); end
      if (c >= 1 && c <= 3) begin
        checks++; if (if_rdata !== exp_data[c-1] || if_err !== 1'b0) begin failures++;
          $display("FAIL b2b_rdata c%0d: if_rdata=%h err=%b expected %h 0", c, if_rdata, if_err,
                   exp_data[c-1]); end
      end
    end
    checks++; if (dbg_state !== 2'd0) begin failures++;
      $display("FAIL b2b_idle: state=%0d expected 0", dbg_state); end
  endtask

`ifndef ROM_ARB_RR_EN
  task automatic test_starvation_guard();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if_req = (c < 5); if_addr = 12'h010;
      d_req  = (c < 6); d_addr  = 12'h100;
      #1;
      if (c < 4) begin
        checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || dbg_wait_cnt !== 3'(c)) begin failures++;
          $display("FAIL starve_d_wins c%0d: d_gnt=%b if_gnt=%b wait=%0d expected 1 0 %0d",
                   c, d_gnt, if_gnt, dbg_wait_cnt, c); end
      end else if (c == 4) begin
        checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || dbg_wait_cnt !== 3'd4 || rom_addr !== 10'd4) begin
          failures++; $display("FAIL starve_if_forced: if_gnt=%b d_gnt=%b wait=%0d rom_addr=%0d expected 1 0 4 4",
                               if_gnt, d_gnt, dbg_wait_cnt, rom_addr); end
      end else if (c == 5) begin
        checks++; if (d_gnt !== 1'b1 || dbg_wait_cnt !== 3'd0 || if_rvalid !== 1'b1 ||
                      if_rdata !== 32'h5A00_0004) begin failures++;
          $display("FAIL starve_after: d_gnt=%b wait=%0d if_rvalid=%b if_rdata=%h expected 1 0 1 5a000004",
                   d_gnt, dbg_wait_cnt, if_rvalid, if_rdata); end
      end
      if (c >= 1 && c <= 4) begin
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h5A00_0040) begin failures++;
          $display("FAIL starve_d_data c%0d: d_rvalid=%b d_rdata=%h expected 1 5a000040", c, d_rvalid, d_rdata); end
      end
    end
  endtask
`else
  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if_req = (c < 6); if_addr = 12'h010;
      d_req  = (c < 7); d_addr  = 12'h100;
      #1;
      if (c < 6) begin
        checks++; if (d_gnt !== ((c % 2) == 0) || if_gnt !== ((c % 2) == 1)) begin failures++;
          $display("FAIL rr_alternate c%0d: d_gnt=%b if_gnt=%b expected %b %b", c, d_gnt, if_gnt,
                   ((c % 2) == 0), ((c % 2) == 1)); end
      end
      if (c >= 1 && c <= 6) begin
        checks++; if (if_rvalid !== ((c % 2) == 0) || d_rvalid !== ((c % 2) == 1)) begin failures++;
          $display("FAIL rr_rvalid c%0d: if_rvalid=%b d_rvalid=%b", c, if_rvalid, d_rvalid); end
      end
    end
  endtask
`endif

  task automatic test_misaligned();
    @(negedge clk);
    d_req = 1'b1; d_addr = 12'h006;
    #1;
    checks++; if (d_gnt !== 1'b1 || rom_addr !== 10'd1) begin failures++;
      $display("FAIL misalign_gnt: d_gnt=%b rom_addr=%0d expected 1 1", d_gnt, rom_addr); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    checks++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin failures++;
      $display("FAIL misalign_resp: d_rvalid=%b d_err=%b d_rdata=%h expected 1 1 0", d_rvalid, d_err, d_rdata); end
    checks++; if (if_rvalid !== 1'b0 || if_err !== 1'b0) begin failures++;
      $display("FAIL misalign_if_quiet: if_rvalid=%b if_err=%b expected 0 0", if_rvalid, if_err); end
  endtask

  task automatic test_hold();
    @(negedge clk);
    if_req = 1'b1; if_addr = 12'h00C;
    #1;
    checks++; if (if_gnt !== 1'b1 || rom_addr !== 10'd3) begin failures++;
      $display("FAIL hold_first_gnt: if_gnt=%b rom_addr=%0d expected 1 3", if_gnt, rom_addr); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b1; d_addr = 12'h020; rom_rdata_valid = 1'b0;
      #1;
      checks++; if (d_gnt !== 1'b0 || if_rvalid !== 1'b0 || rom_addr !== 10'd3) begin failures++;
        $display("FAIL hold_stall c%0d: d_gnt=%b if_rvalid=%b rom_addr=%0d expected 0 0 3",
                 c, d_gnt, if_rvalid, rom_addr); end
      checks++; if (dbg_state !== ((c == 0) ? 2'd1 : 2'd2)) begin failures++;
        $display("FAIL hold_state c%0d: state=%0d expected %0d", c, dbg_state, (c == 0) ? 1 : 2); end
    end
    @(negedge clk);
    rom_rdata_valid = 1'b1;
    #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h5A00_0003 || d_gnt !== 1'b0) begin failures++;
      $display("FAIL hold_release: if_rvalid=%b if_rdata=%h d_gnt=%b expected 1 5a000003 0",
               if_rvalid, if_rdata, d_gnt); end
    @(negedge clk);
    #1;
    checks++; if (d_gnt !== 1'b1 || rom_addr !== 10'd8) begin failures++;
      $display("FAIL hold_next_gnt: d_gnt=%b rom_addr=%0d expected 1 8", d_gnt, rom_addr); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h5A00_0008) begin failures++;
      $display("FAIL hold_next_data: d_rvalid=%b d_rdata=%h expected 1 5a000008", d_rvalid, d_rdata); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    if_req = 1'b1; if_addr = 12'h014;
    #1;
    checks++; if (if_gnt !== 1'b1 || rom_addr !== 10'd5) begin failures++;
      $display("FAIL rstmid_gnt: if_gnt=%b rom_addr=%0d expected 1 5", if_gnt, rom_addr); end
    @(negedge clk);
    if_req = 1'b0; rst_n = 1'b0;
    #1;
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 || dbg_state !== 2'd0) begin failures++;
      $display("FAIL rstmid_during: if_rvalid=%b if_rdata=%h state=%0d expected 0 0 0",
               if_rvalid, if_rdata, dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || rom_addr !== 10'd0 || dbg_state !== 2'd0) begin
        failures++; $display("FAIL rstmid_after c%0d: if_rv=%b d_rv=%b rom_addr=%0d state=%0d expected 0 0 0 0",
                             c, if_rvalid, d_rvalid, rom_addr, dbg_state); end
    end
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; if_addr = '0; d_addr = '0; rom_rdata_valid = 1'b1;
    test_reset();
    test_fetch_back_to_back();
`ifdef ROM_ARB_RR_EN
    test_round_robin();
`else
    test_starvation_guard();
`endif
    test_misaligned();
    test_hold();
    test_reset_mid_access();
    do_reset();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
